packet_scheduler: RTL and testbench

Parametrised packet source arbiter for the HDMI data-island path. Each of `NUM_SOURCES` packet generators raises a pending flag with its header and four subpackets. On each packet slot start the scheduler selects one pending source, by fixed priority or round-robin, and latches that packet into a registered output held for the whole slot. It acknowledges the winner with a one-cycle grant and emits a null packet when nothing is pending.

---
 rtl/packet_scheduler.sv | 169 ++++++++++++++++
 tb/tb_packet_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_scheduler.sv
// Packet source arbiter for the HDMI data-island path.
// On each accepted slot-start strobe one pending source is selected (fixed
// priority or round-robin), its header and subpackets are latched for the
// whole slot, and the winner receives a one-cycle grant. With nothing
// pending a null packet (all zero, source index NUM_SOURCES) is emitted.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no slot in progress, busy=0, outputs hold the last packet
//   ST_SEND | slot in progress, busy=1, cnt_q counts the remaining cycles
module packet_scheduler #(
   parameter int NUM_SOURCES   = 4,
   parameter int PACKET_CYCLES = 32,
   parameter bit ROUND_ROBIN   = 1'b1
) (
   input  logic                               clk_pixel,
   input  logic                               reset_n,
   input  logic                               packet_enable,
   input  logic [NUM_SOURCES-1:0]             pending,
   input  logic [NUM_SOURCES*24-1:0]          headers,
   input  logic [NUM_SOURCES*224-1:0]         subs,
   output logic [NUM_SOURCES-1:0]             grant,
   output logic [23:0]                        header,
   output logic [223:0]                       sub,
   output logic [$clog2(NUM_SOURCES+1)-1:0]   packet_source,
   output logic                               busy,
   output logic                               overrun
);

   localparam int SW = $clog2(NUM_SOURCES + 1);
   localparam int CW = $clog2(PACKET_CYCLES + 1);

   localparam logic [SW-1:0] NULL_SRC = SW'(NUM_SOURCES);
   localparam logic [SW-1:0] LAST_RST = SW'(NUM_SOURCES - 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(PACKET_CYCLES - 1);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SW-1:0]          last_q, last_d;
   logic [NUM_SOURCES-1:0] grant_q, grant_d;
   logic [23:0]            header_q, header_d;
   logic [223:0]           sub_q, sub_d;
   logic [SW-1:0]          src_q, src_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;

   int                       start_idx;
   int                       rot_idx;
   int                       win_int;
   logic [2*NUM_SOURCES-1:0] pend_dbl;
   logic [NUM_SOURCES-1:0]   pend_rot;
   logic                     win_found;
   logic [SW-1:0]            win_idx;
   logic [NUM_SOURCES-1:0]   win_oh;
   logic [23:0]              hdr_sel;
   logic [223:0]             sub_sel;
   logic                     accept;

   // Winner search: rotate pending so the search start sits at bit 0, then
   // take the lowest set bit and map it back to a source index.
   always_comb begin
      start_idx = 0;
      if (ROUND_ROBIN) begin
         start_idx = int'(last_q) + 1;
         if (start_idx >= NUM_SOURCES) start_idx = 0;
      end
      pend_dbl  = {pending, pending} >> start_idx;
      pend_rot  = pend_dbl[NUM_SOURCES-1:0];
      win_found = 1'b0;
      rot_idx   = 0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (pend_rot[i]) begin
            win_found = 1'b1;
            rot_idx   = i;
         end
      end
      win_int = start_idx + rot_idx;
      if (win_int >= NUM_SOURCES) win_int = win_int - NUM_SOURCES;
      win_idx = SW'(win_int);
      win_oh  = win_found ? (NUM_SOURCES'(1) << win_int) : '0;
   end

   // Payload mux for the selected source.
   always_comb begin
      hdr_sel = '0;
      sub_sel = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (win_idx == SW'(i)) begin
            hdr_sel = headers[i*24 +: 24];
            sub_sel = subs[i*224 +: 224];
         end
      end
   end

   // Slot sequencing: accept in IDLE or on the terminal slot cycle, flag
   // strobes that land mid-slot as overrun.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      grant_d   = '0;
      header_d  = header_q;
      sub_d     = sub_q;
      src_d     = src_q;
      overrun_d = overrun_q;

      accept = packet_enable && ((state_q == ST_IDLE) || (cnt_q == '0));

      if (accept) begin
         state_d = ST_SEND;
         cnt_d   = CNT_LOAD;
         if (win_found) begin
            grant_d  = win_oh;
            header_d = hdr_sel;
            sub_d    = sub_sel;
            src_d    = win_idx;
            last_d   = win_idx;
         end else begin
            header_d = '0;
            sub_d    = '0;
            src_d    = NULL_SRC;
         end
      end else if (state_q == ST_SEND) begin
         if (packet_enable) overrun_d = 1'b1;
         if (cnt_q == '0) begin
            state_d = ST_IDLE;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      busy_d = (state_d == ST_SEND);
   end

   // State and registered outputs.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         last_q    <= LAST_RST;
         grant_q   <= '0;
         header_q  <= '0;
         sub_q     <= '0;
         src_q     <= NULL_SRC;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         header_q  <= header_d;
         sub_q     <= sub_d;
         src_q     <= src_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign grant         = grant_q;
   assign header        = header_q;
   assign sub           = sub_q;
   assign packet_source = src_q;
   assign busy          = busy_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler: a round-robin instance and a
// fixed-priority instance share reset and packet inputs but have separate
// strobes. Expected slot contents are queued at stimulus time and popped by
// per-instance monitors whenever a new slot appears on the outputs.
module tb_packet_scheduler;

   localparam int N = 4;
   localparam int P = 32;

   typedef struct {
      logic [3:0]   g;
      logic [23:0]  h;
      logic [223:0] s;
      logic [2:0]   src;
   } exp_t;

   logic             clk_pixel = 1'b0;
   logic             reset_n   = 1'b0;
   logic             pe_rr     = 1'b0;
   logic             pe_fp     = 1'b0;
   logic [N-1:0]     pending   = '0;
   logic [N*24-1:0]  headers;
   logic [N*224-1:0] subs;

   logic [N-1:0]  rr_grant,  fp_grant;
   logic [23:0]   rr_header, fp_header;
   logic [223:0]  rr_sub,    fp_sub;
   logic [2:0]    rr_src,    fp_src;
   logic          rr_busy,   fp_busy;
   logic          rr_ovr,    fp_ovr;

   int tests = 0;
   int fails = 0;

   exp_t rr_q[$];
   exp_t fp_q[$];

   logic       rr_prev_busy = 1'b0, fp_prev_busy = 1'b0;
   logic [2:0] rr_prev_src = 3'd4,  fp_prev_src = 3'd4;

   always #5 clk_pixel = ~clk_pixel;

   packet_scheduler #(.NUM_SOURCES(N), .PACKET_CYCLES(P), .ROUND_ROBIN(1'b1)) dut_rr (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_enable(pe_rr),
      .pending(pending), .headers(headers), .subs(subs),
      .grant(rr_grant), .header(rr_header), .sub(rr_sub),
      .packet_source(rr_src), .busy(rr_busy), .overrun(rr_ovr));

   packet_scheduler #(.NUM_SOURCES(N), .PACKET_CYCLES(P), .ROUND_ROBIN(1'b0)) dut_fp (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_enable(pe_fp),
      .pending(pending), .headers(headers), .subs(subs),
      .grant(fp_grant), .header(fp_header), .sub(fp_sub),
      .packet_source(fp_src), .busy(fp_busy), .overrun(fp_ovr));

   function automatic logic [23:0] hdr_of(int i);
      logic [23:0] one;
      one = 24'd1;
      return one << (2 * i);
   endfunction

   function automatic logic [223:0] sub_of(int i);
      logic [223:0] r;
      r = '0;
      for (int j = 0; j < 4; j++) r[56*j +: 56] = {48'hABCDEF012345, 4'(i), 4'(j)};
      return r;
   endfunction

   function automatic void chk(string name, logic [255:0] act, logic [255:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   function automatic exp_t mk(logic [3:0] g, int src);
      exp_t e;
      e.g   = g;
      e.src = 3'(src);
      e.h   = (src < N) ? hdr_of(src) : 24'h0;
      e.s   = (src < N) ? sub_of(src) : 224'h0;
      return e;
   endfunction

   // Round-robin monitor: a new slot shows as a grant, a busy rise or a source change.
   always @(negedge clk_pixel) begin
      exp_t e;
      if (!reset_n) begin
         rr_prev_busy <= 1'b0;
         rr_prev_src  <= 3'd4;
      end else begin
         if (rr_grant != '0 || (rr_busy && !rr_prev_busy) || rr_src != rr_prev_src) begin
            if (rr_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL rr_unexpected_slot actual grant=%b src=%0d required no new slot", rr_grant, rr_src);
            end else begin
               e = rr_q.pop_front();
               chk("rr_grant",  256'(rr_grant),  256'(e.g));
               chk("rr_header", 256'(rr_header), 256'(e.h));
               chk("rr_sub",    256'(rr_sub),    256'(e.s));
               chk("rr_src",    256'(rr_src),    256'(e.src));
            end
         end
         rr_prev_busy <= rr_busy;
         rr_prev_src  <= rr_src;
      end
   end

   // Fixed-priority monitor.
   always @(negedge clk_pixel) begin
      exp_t e;
      if (!reset_n) begin
         fp_prev_busy <= 1'b0;
         fp_prev_src  <= 3'd4;
      end else begin
         if (fp_grant != '0 || (fp_busy && !fp_prev_busy) || fp_src != fp_prev_src) begin
            if (fp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL fp_unexpected_slot actual grant=%b src=%0d required no new slot", fp_grant, fp_src);
            end else begin
               e = fp_q.pop_front();
               chk("fp_grant",  256'(fp_grant),  256'(e.g));
               chk("fp_header", 256'(fp_header), 256'(e.h));
               chk("fp_sub",    256'(fp_sub),    256'(e.s));
               chk("fp_src",    256'(fp_src),    256'(e.src));
            end
         end
         fp_prev_busy <= fp_busy;
         fp_prev_src  <= fp_src;
      end
   end

   task automatic strobe_rr();
      pe_rr = 1'b1;
      @(negedge clk_pixel);
      pe_rr = 1'b0;
   endtask

   task automatic strobe_fp();
      pe_fp = 1'b1;
      @(negedge clk_pixel);
      pe_fp = 1'b0;
   endtask

   task automatic wait_cycles(int n);
      repeat (n) @(negedge clk_pixel);
   endtask

   initial begin
      int busy_cnt;
      for (int i = 0; i < N; i++) begin
         headers[24*i +: 24] = hdr_of(i);
         subs[224*i +: 224]  = sub_of(i);
      end

      // Reset values while reset is held.
      #12;
      chk("rst_src",     256'(rr_src),    256'(4));
      chk("rst_busy",    256'(rr_busy),   256'(0));
      chk("rst_overrun", 256'(rr_ovr),    256'(0));
      chk("rst_grant",   256'(rr_grant),  256'(0));
      chk("rst_header",  256'(rr_header), 256'(0));
      chk("rst_fp_src",  256'(fp_src),    256'(4));
      @(negedge clk_pixel);
      #2 reset_n = 1'b1;
      wait_cycles(2);

      // Fixed priority: lowest set index of 1010 is source 1.
      pending = 4'b1010;
      fp_q.push_back(mk(4'b0010, 1));
      strobe_fp();
      busy_cnt = 0;
      for (int i = 0; i < 40 && fp_busy; i++) begin
         busy_cnt++;
         @(negedge clk_pixel);
      end
      chk("fp_busy_len",    256'(busy_cnt),  256'(P));
      chk("fp_hold_header", 256'(fp_header), 256'(24'h000004));
      chk("fp_hold_src",    256'(fp_src),    256'(1));

      // Round-robin, all pending, back-to-back slots.
      pending = 4'b1111;
      rr_q.push_back(mk(4'b0001, 0));
      strobe_rr();
      wait_cycles(31);
      rr_q.push_back(mk(4'b0010, 1));
      strobe_rr();
      chk("rr_b2b_busy", 256'(rr_busy), 256'(1));
      wait_cycles(31);
      rr_q.push_back(mk(4'b0100, 2));
      strobe_rr();
      wait_cycles(31);
      rr_q.push_back(mk(4'b1000, 3));
      strobe_rr();
      wait_cycles(31);
      rr_q.push_back(mk(4'b0001, 0));
      strobe_rr();
      wait_cycles(40);
      chk("rr_idle_after", 256'(rr_busy), 256'(0));

      // Null packet, then round-robin resumes from source 1.
      pending = 4'b0000;
      rr_q.push_back(mk(4'b0000, N));
      strobe_rr();
      wait_cycles(40);
      pending = 4'b1111;
      rr_q.push_back(mk(4'b0010, 1));
      strobe_rr();

      // Strobe at cnt=10 is ignored and sets overrun.
      wait_cycles(10);
      strobe_rr();
      chk("ovr_set",      256'(rr_ovr),  256'(1));
      chk("ovr_src_hold", 256'(rr_src),  256'(1));
      chk("ovr_busy",     256'(rr_busy), 256'(1));
      // Strobe at cnt=31 is accepted back-to-back.
      wait_cycles(20);
      rr_q.push_back(mk(4'b0100, 2));
      strobe_rr();
      chk("last_cycle_busy", 256'(rr_busy), 256'(1));
      wait_cycles(100);
      chk("ovr_sticky", 256'(rr_ovr), 256'(1));

      // Reset mid-slot while source 2 sends.
      pending = 4'b0100;
      rr_q.push_back(mk(4'b0100, 2));
      strobe_rr();
      wait_cycles(16);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_busy",   256'(rr_busy),   256'(0));
      chk("mid_rst_grant",  256'(rr_grant),  256'(0));
      chk("mid_rst_header", 256'(rr_header), 256'(0));
      chk("mid_rst_sub",    256'(rr_sub),    256'(0));
      chk("mid_rst_src",    256'(rr_src),    256'(4));
      chk("mid_rst_ovr",    256'(rr_ovr),    256'(0));
      @(negedge clk_pixel);
      #2 reset_n = 1'b1;
      @(negedge clk_pixel);
      pending = 4'b1111;
      wait_cycles(5);
      chk("post_rst_idle", 256'(rr_busy), 256'(0));
      rr_q.push_back(mk(4'b0001, 0));
      strobe_rr();
      wait_cycles(40);

      chk("rr_queue_drained", 256'(rr_q.size()), 256'(0));
      chk("fp_queue_drained", 256'(fp_q.size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
